// File: rtl/mvm_stream_host.sv
// mvm_stream_host: holds one matrix-vector job, streams its operands to the
// accelerator, collects the results for readback, and aborts stalled handshakes.
module mvm_stream_host #(
  parameter int N       = 3,
  parameter int IW      = 8,
  parameter int OW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic [3:0]    ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IW-1:0] m_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [OW-1:0] s_data,
  input  logic          s_overflow,
  input  logic [1:0]    rd_addr,
  output logic [OW-1:0] rd_data,
  output logic          rd_ovf,
  output logic          ovf_any
);

  // state | meaning
  // IDLE  | operands loadable, waiting for start
  // SEND  | streaming A row-major then x to the accelerator
  // RECV  | accepting the N results
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  localparam int NW  = N*N + N;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]     LAST_WORD = 4'(NW - 1);
  localparam logic [1:0]     LAST_RES  = 2'(N - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT - 1);

  state_t         state, state_next;
  logic [IW-1:0]  inbuf  [NW];
  logic [OW:0]    resbuf [N];
  logic [3:0]     send_cnt;
  logic [1:0]     recv_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           send_hs, recv_hs, wd_expire;

  assign send_hs   = m_valid & m_ready;
  assign recv_hs   = s_valid & s_ready;
  // A handshake in the limit cycle counts as progress, not as a stall.
  assign wd_expire = (state == SEND || state == RECV) && !send_hs && !recv_hs
                     && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SEND;
      SEND: begin
        if (send_hs && send_cnt == LAST_WORD) state_next = RECV;
        else if (wd_expire)                   state_next = IDLE;
      end
      RECV: begin
        if (recv_hs && recv_cnt == LAST_RES) state_next = DONE;
        else if (wd_expire)                  state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      SEND: begin
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      RECV: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_data = (send_cnt <= LAST_WORD) ? inbuf[send_cnt] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      send_cnt <= '0;
      recv_cnt <= '0;
      ovf_any  <= 1'b0;
      err      <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      err <= wd_expire;
      if (state == IDLE && start) begin
        send_cnt <= '0;
        recv_cnt <= '0;
        ovf_any  <= 1'b0;
      end
      if (send_hs) send_cnt <= send_cnt + 4'd1;
      if (recv_hs) begin
        recv_cnt <= recv_cnt + 2'd1;
        ovf_any  <= ovf_any | s_overflow;
      end
      if (state_next != state || send_hs || recv_hs) wd_cnt <= '0;
      else if (state == SEND || state == RECV)       wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  // Buffers carry no reset; only the readback register is cleared.
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_en && ld_addr <= LAST_WORD) inbuf[ld_addr] <= ld_data;
    if (!reset && recv_hs) resbuf[recv_cnt] <= {s_overflow, s_data};
  end

  always_ff @(posedge clk) begin
    if (reset)                     {rd_ovf, rd_data} <= '0;
    else if (rd_addr <= LAST_RES)  {rd_ovf, rd_data} <= resbuf[rd_addr];
    else                           {rd_ovf, rd_data} <= '0;
  end

endmodule

// File: doc/mvm_stream_host.md
# mvm_stream_host

Stream initiator and collector for the 3x3 matrix-vector accelerator. It holds one job's operands, with matrix A row-major followed by vector x, in a local buffer. On start it drives them over a valid/ready master port into the accelerator's input stream, then accepts the N 16-bit results and their overflow flags on a valid/ready slave port and stores them for readback. It sits between the system load/readback logic and the accelerator and includes a handshake watchdog.

## Interface
- N, 3, matrix/vector dimension; one job = N*N+N input words, N results
- IW, 8, input word width (signed)
- OW, 16, result width (signed)
- TIMEOUT, 1024, max cycles without a handshake in SEND/RECV before abort
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ld_en  in  1  write ld_data to input buffer at ld_addr (honoured in IDLE only)
- ld_addr  in  4  input buffer index 0..N*N+N-1; A[r][c] at r*N+c, x[k] at N*N+k
- ld_data  in  IW  operand word
- start  in  1  launch job (honoured in IDLE only)
- busy  out  1  high in SEND, RECV, DONE
- done  out  1  one-cycle pulse on job completion
- err  out  1  one-cycle pulse on watchdog abort
- m_valid  out  1  to accelerator s_valid
- m_ready  in  1  from accelerator s_ready
- m_data  out  IW  to accelerator data_in
- s_valid  in  1  from accelerator m_valid
- s_ready  out  1  to accelerator m_ready
- s_data  in  OW  from accelerator data_out
- s_overflow  in  1  from accelerator overflow
- rd_addr  in  2  result index
- rd_data  out  OW  result at rd_addr
- rd_ovf  out  1  overflow flag at rd_addr
- ovf_any  out  1  OR of all overflow flags of the last job

## Operation
- FSM states: IDLE, SEND, RECV, DONE. Reset sets IDLE, clears counters, and clears busy, done, err, m_valid, s_ready, rd_data, rd_ovf and ovf_any. Buffer contents are not reset.
- IDLE:
  - ld_en writes inbuf[ld_addr]. ld_addr >= N*N+N is ignored.
  - start moves to SEND, clears send_cnt, recv_cnt, ovf_any and the watchdog.
  - ld_en and start in the same cycle: the write lands, and SEND transmits the new value.
- SEND:
  - m_valid=1, m_data=inbuf[send_cnt].
  - A transfer occurs when m_valid&m_ready. It increments send_cnt.
  - m_data holds stable until the transfer. m_valid never drops mid-job.
  - The transfer with send_cnt==N*N+N-1 moves to RECV.
  - ld_en and start are ignored here.
- RECV:
  - s_ready=1, m_valid=0.
  - On s_valid&s_ready: resbuf[recv_cnt] <= {s_overflow, s_data}, ovf_any <= ovf_any|s_overflow, recv_cnt++.
  - The handshake with recv_cnt==N-1 moves to DONE.
  - s_valid outside RECV is ignored (s_ready=0), and no result is written.
- DONE: done=1 for exactly one cycle, then IDLE.
- Watchdog:
  - The counter clears on state entry and on every handshake in the current state.
  - When the counter reaches TIMEOUT-1 in SEND or RECV: err pulses one cycle and the FSM returns to IDLE with no done.
  - Results already captured are retained. ovf_any reflects only the captured results.
- Readback:
  - rd_data/rd_ovf <= resbuf[rd_addr], registered, every cycle regardless of state.
  - rd_addr >= N returns 0/0.
- reset mid-job aborts immediately to IDLE. No done or err pulse.

## Timing
- start sampled at edge k: m_valid=1 from cycle k+1.
- m_ready held high: all N*N+N words transfer in consecutive cycles. The first result can be accepted the cycle after the last send handshake.
- The last result handshake at edge t gives done=1 in cycle t+1 and busy=0 from cycle t+2.
- Readback latency is 1 cycle.
- All control outputs (m_valid, s_ready, busy) are decoded from the registered state, with no combinational path from m_ready or s_valid. m_data is a combinational buffer read indexed by registered send_cnt.

## Test plan
- Basic job, ready/valid held high:
  - Load A=[1,-8,3;9,-5,11;-7,8,-9], x=[1,-22,3]; start.
  - m_data sequence is 1,-8,3,9,-5,11,-7,8,-9,1,-22,3 on 12 consecutive cycles.
  - Drive results 186,152,-210, overflow 0. Expect done one cycle after the last, rd_data[0..2]=186,152,-210, ovf_any=0.
- Random backpressure: randomize m_ready and s_valid 50% against the full accelerator, using A=[10,11,12;127,127,127;1,2,3], x=[127,127,127]. Expect results 4191,-17149,762, rd_ovf[1]=1, ovf_any=1, and m_data stable whenever m_valid&!m_ready.
- Protocol guards: hold s_valid=1 during SEND, and assert start and ld_en during RECV. Expect s_ready=0 in SEND, no result written, the buffer unchanged, and no restart.
- Same-cycle load+start: write ld_addr=0 with 55 together with start. Expect the first m_data=55.
- Watchdog with TIMEOUT=16: hold m_ready=0 after 5 sends. Expect err pulse 16 cycles after the 5th handshake, IDLE, no done. A following start resends from word 0.
- Reset mid-RECV after 1 result. Expect m_valid=s_ready=busy=0 next cycle, no done or err, rd_data=0.
